// File: rtl/matmul_sequencer.sv
// Address/control sequencer for one C = A x B pass over DIM x DIM row-major matrices.
// Issues operand reads, drives the MAC enables one cycle later and writes each C element.
module matmul_sequencer #(
  parameter int DIM = 4,
  parameter int AW  = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic          hold,
  input  logic          abort,
  output logic [AW-1:0] addr_a,
  output logic [AW-1:0] addr_b,
  output logic [AW-1:0] addr_c,
  output logic          mem_rd_en,
  output logic          mac_en,
  output logic          mac_clr,
  output logic          c_wr_en,
  output logic          busy,
  output logic          done,
  output logic [1:0]    status
);

  localparam int CW = (DIM < 2) ? 1 : $clog2(DIM);
  localparam logic [CW-1:0] LAST = CW'(DIM - 1);
  localparam logic [AW-1:0] DIM_A = AW'(DIM);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] i_q, i_d;
  logic [CW-1:0] j_q, j_d;
  logic [CW-1:0] k_q, k_d;
  logic [AW-1:0] addr_a_q, addr_b_q, addr_c_q;
  logic          mac_en_q, mac_en_d;
  logic          mac_clr_q, mac_clr_d;
  logic          rd_s, wr_s;
  logic [AW-1:0] a_idx_s, b_idx_s, c_idx_s;

  assign a_idx_s = AW'(i_q) * DIM_A + AW'(k_q);
  assign b_idx_s = AW'(k_q) * DIM_A + AW'(j_q);
  assign c_idx_s = AW'(i_q) * DIM_A + AW'(j_q);

  // Next-state, loop counters and read/write strobes.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    rd_s    = 1'b0;
    wr_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        // A read issued in the abort cycle still completes into the MAC.
        rd_s = ~hold;
        if (abort) begin
          state_d = S_IDLE;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end else if (!hold) begin
          if (k_q == LAST) begin
            state_d = S_DRAIN;
            k_d     = '0;
          end else begin
            k_d = k_q + CW'(1);
          end
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_d = S_IDLE;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        wr_s = 1'b1;
        k_d  = '0;
        if (abort) begin
          state_d = S_IDLE;
          i_d     = '0;
          j_d     = '0;
        end else if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) begin
            i_d     = '0;
            state_d = S_DONE;
          end else begin
            i_d     = i_q + CW'(1);
            state_d = S_FETCH;
          end
        end else begin
          j_d     = j_q + CW'(1);
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        i_d     = '0;
        j_d     = '0;
        k_d     = '0;
      end
    endcase
  end

  // MAC controls trail the read by one cycle.
  always_comb begin
    mac_en_d  = rd_s;
    mac_clr_d = rd_s & (k_q == '0);
  end

  // Output decode; addresses fall back to their last qualified value.
  always_comb begin
    mem_rd_en = rd_s;
    c_wr_en   = wr_s;
    mac_en    = mac_en_q;
    mac_clr   = mac_clr_q;
    addr_a    = rd_s ? a_idx_s : addr_a_q;
    addr_b    = rd_s ? b_idx_s : addr_b_q;
    addr_c    = wr_s ? c_idx_s : addr_c_q;
    busy      = 1'b0;
    done      = 1'b0;
    status    = 2'b00;
    case (state_q)
      S_FETCH, S_DRAIN: begin
        busy   = 1'b1;
        status = 2'b01;
      end
      S_WRITE: begin
        busy   = 1'b1;
        status = 2'b10;
      end
      S_DONE: begin
        done   = 1'b1;
        status = 2'b11;
      end
      default: begin
        busy   = 1'b0;
        status = 2'b00;
      end
    endcase
  end

  // State, counters, held addresses and delayed MAC controls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      addr_c_q  <= '0;
      mac_en_q  <= 1'b0;
      mac_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      addr_a_q  <= addr_a;
      addr_b_q  <= addr_b;
      addr_c_q  <= addr_c;
      mac_en_q  <= mac_en_d;
      mac_clr_q <= mac_clr_d;
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer: DIM=4 instance for the main scenarios, DIM=1 for the degenerate case.
module tb_matmul_sequencer;

  logic       clock;
  logic       reset_n;
  logic       start, hold, abort;
  logic [3:0] addr_a, addr_b, addr_c;
  logic       mem_rd_en, mac_en, mac_clr, c_wr_en, busy, done;
  logic [1:0] status;

  logic       start1;
  logic [3:0] addr_a1, addr_b1, addr_c1;
  logic       mem_rd_en1, mac_en1, mac_clr1, c_wr_en1, busy1, done1;
  logic [1:0] status1;

  int n_tot  = 0;
  int n_pass = 0;
  int wr_total = 0;

  matmul_sequencer #(.DIM(4), .AW(4)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .hold(hold), .abort(abort),
    .addr_a(addr_a), .addr_b(addr_b), .addr_c(addr_c), .mem_rd_en(mem_rd_en),
    .mac_en(mac_en), .mac_clr(mac_clr), .c_wr_en(c_wr_en), .busy(busy),
    .done(done), .status(status)
  );

  matmul_sequencer #(.DIM(1), .AW(4)) dut1 (
    .clock(clock), .reset_n(reset_n), .start(start1), .hold(1'b0), .abort(1'b0),
    .addr_a(addr_a1), .addr_b(addr_b1), .addr_c(addr_c1), .mem_rd_en(mem_rd_en1),
    .mac_en(mac_en1), .mac_clr(mac_clr1), .c_wr_en(c_wr_en1), .busy(busy1),
    .done(done1), .status(status1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (c_wr_en === 1'b1) wr_total <= wr_total + 1;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    int st_in, hd_in, ab_in;
    int rd, aa, ab, me, mc, wr, ac, bz, dn, st;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic chk_all(input string tag, input int rd, input int aa, input int ab,
                         input int me, input int mc, input int wr, input int ac,
                         input int bz, input int dn, input int st);
    chk({tag, ".mem_rd_en"}, int'(mem_rd_en), rd);
    chk({tag, ".addr_a"},    int'(addr_a),    aa);
    chk({tag, ".addr_b"},    int'(addr_b),    ab);
    chk({tag, ".mac_en"},    int'(mac_en),    me);
    chk({tag, ".mac_clr"},   int'(mac_clr),   mc);
    chk({tag, ".c_wr_en"},   int'(c_wr_en),   wr);
    chk({tag, ".addr_c"},    int'(addr_c),    ac);
    chk({tag, ".busy"},      int'(busy),      bz);
    chk({tag, ".done"},      int'(done),      dn);
    chk({tag, ".status"},    int'(status),    st);
  endtask

  task automatic next_cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int i, j, n, wr0, bad_wr, bad_dn;
    bit found;
    reset_n = 1'b0;
    start = 1'b0; hold = 1'b0; abort = 1'b0; start1 = 1'b0;

    //                st hd ab  rd aa  ab me mc wr ac bz dn st
    tbl[0] = '{0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{0, 0, 0,  1, 0,  0, 0, 0, 0, 0, 1, 0, 1};
    tbl[3] = '{0, 0, 0,  1, 1,  4, 1, 1, 0, 0, 1, 0, 1};
    tbl[4] = '{0, 0, 0,  1, 2,  8, 1, 0, 0, 0, 1, 0, 1};
    tbl[5] = '{0, 0, 0,  1, 3, 12, 1, 0, 0, 0, 1, 0, 1};
    tbl[6] = '{0, 0, 0,  0, 3, 12, 1, 0, 0, 0, 1, 0, 1};
    tbl[7] = '{0, 0, 0,  0, 3, 12, 0, 0, 1, 0, 1, 0, 2};

    repeat (2) @(posedge clock);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    next_cyc();
    wr0 = wr_total;

    // Table: idle, start, and the complete first element of a pass.
    for (int r = 0; r < 8; r++) begin
      start = 1'(tbl[r].st_in); hold = 1'(tbl[r].hd_in); abort = 1'(tbl[r].ab_in);
      #2;
      chk_all($sformatf("tbl%0d", r), tbl[r].rd, tbl[r].aa, tbl[r].ab, tbl[r].me,
              tbl[r].mc, tbl[r].wr, tbl[r].ac, tbl[r].bz, tbl[r].dn, tbl[r].st);
      next_cyc();
    end
    start = 1'b0;

    // Remaining elements from a loop-nest reference.
    for (int e = 1; e < 16; e++) begin
      i = e / 4; j = e % 4;
      for (int k = 0; k < 4; k++) begin
        #2;
        chk_all($sformatf("e%0d.k%0d", e, k), 1, i*4+k, k*4+j, (k > 0) ? 1 : 0,
                (k == 1) ? 1 : 0, 0, e-1, 1, 0, 1);
        next_cyc();
      end
      #2;
      chk_all($sformatf("e%0d.drain", e), 0, i*4+3, 12+j, 1, 0, 0, e-1, 1, 0, 1);
      next_cyc();
      #2;
      chk_all($sformatf("e%0d.write", e), 0, i*4+3, 12+j, 0, 0, 1, e, 1, 0, 2);
      next_cyc();
    end
    #2;
    chk_all("done", 0, 15, 15, 0, 0, 0, 15, 0, 1, 3);
    next_cyc();
    #2;
    chk("after_done.status", int'(status), 0);
    chk("after_done.done", int'(done), 0);
    chk("pass.n_writes", wr_total - wr0, 16);

    // Hold for three cycles after the second read.
    start = 1'b1;
    #2;
    next_cyc();
    start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      hold = (c >= 3 && c <= 5);
      #2;
      chk($sformatf("hold.c%0d.rd", c), int'(mem_rd_en), (c <= 2 || c == 6 || c == 7) ? 1 : 0);
      chk($sformatf("hold.c%0d.wr", c), int'(c_wr_en), (c == 9) ? 1 : 0);
      if (c >= 3 && c <= 5) chk($sformatf("hold.c%0d.aa_held", c), int'(addr_a), 1);
      if (c == 6) begin
        chk("hold.resume.aa", int'(addr_a), 2);
        chk("hold.resume.ab", int'(addr_b), 8);
      end
      next_cyc();
    end
    hold = 1'b0;

    // Abort in the WRITE cycle of element 5.
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      #2;
      if (c_wr_en && addr_c == 4'd5) begin
        found = 1'b1;
        abort = 1'b1;
        next_cyc();
        abort = 1'b0;
        break;
      end
      next_cyc();
    end
    chk("abort_wr.found", int'(found), 1);
    #2;
    chk("abort_wr.status", int'(status), 0);
    bad_wr = 0; bad_dn = 0;
    for (int c = 0; c < 20; c++) begin
      if (c_wr_en) bad_wr++;
      if (done) bad_dn++;
      next_cyc();
      #2;
    end
    chk("abort_wr.no_write", bad_wr, 0);
    chk("abort_wr.no_done", bad_dn, 0);
    next_cyc();

    // Abort in FETCH: the in-flight read still produces one mac_en, no write.
    start = 1'b1;
    #2;
    next_cyc();
    start = 1'b0;
    abort = 1'b1;
    #2;
    chk("abort_rd.rd", int'(mem_rd_en), 1);
    next_cyc();
    abort = 1'b0;
    #2;
    chk("abort_rd.status", int'(status), 0);
    chk("abort_rd.mac_en", int'(mac_en), 1);
    chk("abort_rd.mac_clr", int'(mac_clr), 1);
    next_cyc();
    #2;
    chk("abort_rd.mac_en_off", int'(mac_en), 0);
    bad_wr = 0;
    for (int c = 0; c < 10; c++) begin
      if (c_wr_en) bad_wr++;
      next_cyc();
      #2;
    end
    chk("abort_rd.no_write", bad_wr, 0);
    next_cyc();

    // start held high for a whole pass.
    start = 1'b1;
    #2;
    next_cyc();
    n = 1;
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      #2;
      if (done) begin
        found = 1'b1;
        break;
      end
      n++;
      next_cyc();
    end
    chk("start_held.done_seen", int'(found), 1);
    chk("start_held.cycles_to_done", n, 97);
    next_cyc();
    #2;
    chk("start_held.idle", int'(status), 0);
    next_cyc();
    #2;
    chk("start_held.restart", int'(status), 1);
    start = 1'b0;
    abort = 1'b1;
    next_cyc();
    abort = 1'b0;

    // Reset mid-FETCH with a pending mac_en.
    start = 1'b1;
    #2;
    next_cyc();
    start = 1'b0;
    next_cyc();
    #2;
    chk("pre_rst.mac_en", int'(mac_en), 1);
    reset_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    next_cyc();
    #2;
    chk("post_rst.status", int'(status), 0);
    chk("post_rst.rd", int'(mem_rd_en), 0);

    // DIM=1: read, drain, write, done.
    start1 = 1'b1;
    #2;
    next_cyc();
    start1 = 1'b0;
    #2;
    chk("d1.fetch.rd", int'(mem_rd_en1), 1);
    chk("d1.fetch.aa", int'(addr_a1), 0);
    chk("d1.fetch.ab", int'(addr_b1), 0);
    chk("d1.fetch.status", int'(status1), 1);
    next_cyc();
    #2;
    chk("d1.drain.rd", int'(mem_rd_en1), 0);
    chk("d1.drain.mac_en", int'(mac_en1), 1);
    chk("d1.drain.mac_clr", int'(mac_clr1), 1);
    chk("d1.drain.status", int'(status1), 1);
    next_cyc();
    #2;
    chk("d1.write.wr", int'(c_wr_en1), 1);
    chk("d1.write.ac", int'(addr_c1), 0);
    chk("d1.write.status", int'(status1), 2);
    next_cyc();
    #2;
    chk("d1.done.done", int'(done1), 1);
    chk("d1.done.busy", int'(busy1), 0);
    chk("d1.done.status", int'(status1), 3);
    next_cyc();
    #2;
    chk("d1.idle.status", int'(status1), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/matmul_sequencer.md
MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 The block SHALL have parameter DIM, default 4, giving square matrix dimension (legal range 1..15).
REQ-002 The block SHALL have parameter AW, default 4, giving address width; DIM*DIM <= 2**AW is required.
REQ-003 The block SHALL have port clock, input, 1, the single rising-edge clock.
REQ-004 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, request to begin one C = A x B pass.
REQ-006 The block SHALL have port hold, input, 1, stall: suppresses issuing a new operand read.
REQ-007 The block SHALL have port abort, input, 1, synchronous cancel of the current pass.
REQ-008 The block SHALL have ports addr_a, addr_b, addr_c, output, AW each, operand and result addresses (row-major, base 0).
REQ-009 The block SHALL have port mem_rd_en, output, 1, reads A[addr_a] and B[addr_b]; data is valid the next cycle.
REQ-010 The block SHALL have ports mac_en and mac_clr, output, 1 each; mac_clr means load the product instead of accumulating.
REQ-011 The block SHALL have port c_wr_en, output, 1, writes the accumulator to C[addr_c].
REQ-012 The block SHALL have ports busy, done (output, 1 each) and status (output, 2): IDLE=00, RUN=01, WRITE=10, DONE=11.

Function
REQ-013 States SHALL be IDLE, FETCH, DRAIN, WRITE, DONE; status = 00 in IDLE, 01 in FETCH/DRAIN, 10 in WRITE, 11 in DONE.
REQ-014 In IDLE, start=1 at a clock edge SHALL enter FETCH with i=j=k=0.
REQ-015 start SHALL be ignored in every state except IDLE.
REQ-016 In FETCH with hold=0, mem_rd_en SHALL be 1, addr_a = i*DIM+k, addr_b = k*DIM+j, and k SHALL increment.
REQ-017 In FETCH with hold=1, mem_rd_en SHALL be 0, with k and the state unchanged.
REQ-018 After the read with k=DIM-1 is issued, the next state SHALL be DRAIN (one cycle, no read).
REQ-019 mac_en SHALL be a one-cycle-delayed copy of mem_rd_en.
REQ-020 mac_clr SHALL be a one-cycle-delayed copy of (mem_rd_en AND k==0); it is independent of hold.
REQ-021 WRITE SHALL last one cycle with c_wr_en=1 and addr_c = i*DIM+j; then j increments, wrapping to 0 and incrementing i at j=DIM-1.
REQ-022 After WRITE, the next state SHALL be FETCH with k=0, except after element (DIM-1,DIM-1), when it SHALL be DONE.
REQ-023 DONE SHALL last one cycle with done=1, then the next state SHALL be IDLE.
REQ-024 busy SHALL be 1 in FETCH, DRAIN and WRITE, and 0 in IDLE and DONE.
REQ-025 Latency without hold: each element SHALL take DIM+2 cycles, and a pass SHALL take DIM*DIM*(DIM+2) cycles from the first FETCH to the last WRITE inclusive.
REQ-026 abort=1 in any non-IDLE state SHALL go to IDLE at the next edge with no done pulse; abort SHALL take priority over hold and state transitions.
REQ-027 One mac_en SHALL still follow a read issued in the abort cycle, but there SHALL be no c_wr_en.
REQ-028 Address outputs SHALL hold their last value when not qualified by mem_rd_en or c_wr_en.
REQ-029 With DIM=1: FETCH SHALL last one read (k=0 is also last), and each read SHALL produce mac_clr=1.

Reset
REQ-030 While reset_n=0, the block SHALL asynchronously be in IDLE with i=j=k=0.
REQ-031 While reset_n=0, all outputs SHALL be 0: addresses, mem_rd_en, mac_en, mac_clr, c_wr_en, busy, done, and status=00.
REQ-032 Reset asserted mid-pass SHALL discard the pass, including any pending mac_en; on release the block SHALL wait in IDLE for start.

Verification
REQ-033 DIM=4, start pulse, hold=0 -> reads with (addr_a,addr_b) = (0,0),(1,4),(2,8),(3,12).
REQ-034 Same run -> mac_clr only on the first mac_en of each element, first c_wr_en at addr_c=0 on cycle 6, 16 writes in total, then done for 1 cycle after write 16 (cycle 96).
REQ-035 hold=1 for 3 cycles after the second read -> mem_rd_en low for 3 cycles, resuming with addr_a=2, addr_b=8; the element's write is delayed by exactly 3 cycles.
REQ-036 abort during WRITE of element 5 -> status=00 next cycle, no done, and no further c_wr_en.
REQ-037 start held high throughout the pass -> a new pass begins only on the edge after DONE (IDLE entered, then FETCH).
REQ-038 reset_n low mid-FETCH, then DIM=1 rebuild and run -> all outputs 0 immediately; after start, a pattern of read, DRAIN, write, done within 4 cycles.
